// File: rtl/str_frame_if.sv
// Handshake bundle for the stream framer: length config, untagged upstream
// beats and framed downstream beats.
interface str_frame_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
);
   logic [LEN_WIDTH-1:0]  cfg_len;
   logic                  cfg_val;
   logic                  cfg_rdy;
   logic [DATA_WIDTH-1:0] up_data;
   logic                  up_val;
   logic                  up_rdy;
   logic [DATA_WIDTH-1:0] dn_data;
   logic                  dn_last;
   logic                  dn_val;
   logic                  dn_rdy;

   modport master (
      output cfg_len, cfg_val, up_data, up_val, dn_rdy,
      input  cfg_rdy, up_rdy, dn_data, dn_last, dn_val
   );

   modport slave (
      input  cfg_len, cfg_val, up_data, up_val, dn_rdy,
      output cfg_rdy, up_rdy, dn_data, dn_last, dn_val
   );
endinterface

// File: rtl/str_frame.sv
// Stream framer: tags a run of cfg_len upstream beats with last on the final
// beat, through a registered output stage backed by a one-entry skid buffer.
module str_frame #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic       clk,
   input  logic       rst,
   str_frame_if.slave bus,
   output logic       busy
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t                state;
   logic [LEN_WIDTH-1:0]  remain;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  out_val;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  skid_last;
   logic                  skid_val;
   logic                  cfg_fire;
   logic                  up_fire;
   logic                  drain;
   logic                  beat_last;

   // Ready only depends on registers, so dn_rdy never reaches up_rdy.
   assign bus.cfg_rdy = rst & (state == IDLE);
   assign bus.up_rdy  = rst & (state == RUN) & ~skid_val;

   assign cfg_fire  = bus.cfg_val & bus.cfg_rdy;
   assign up_fire   = bus.up_val & bus.up_rdy;
   assign drain     = ~out_val | bus.dn_rdy;
   assign beat_last = (remain == LEN_WIDTH'(1));

   assign bus.dn_data = out_data;
   assign bus.dn_last = out_last;
   assign bus.dn_val  = out_val;
   assign busy        = (state == RUN) | out_val | skid_val;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         remain <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_fire && (bus.cfg_len != '0)) begin
                  remain <= bus.cfg_len;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (up_fire) begin
                  remain <= remain - LEN_WIDTH'(1);
                  if (beat_last) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // up_rdy is low whenever the skid is full, so a skid refill and a new
   // upstream beat can never compete for the output register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_data  <= '0;
         out_last  <= 1'b0;
         out_val   <= 1'b0;
         skid_data <= '0;
         skid_last <= 1'b0;
         skid_val  <= 1'b0;
      end else if (drain) begin
         if (skid_val) begin
            out_data <= skid_data;
            out_last <= skid_last;
            out_val  <= 1'b1;
            skid_val <= 1'b0;
         end else if (up_fire) begin
            out_data <= bus.up_data;
            out_last <= beat_last;
            out_val  <= 1'b1;
         end else begin
            out_val <= 1'b0;
         end
      end else if (up_fire) begin
         skid_data <= bus.up_data;
         skid_last <= beat_last;
         skid_val  <= 1'b1;
      end
   end
endmodule

// File: tb/tb_str_frame.sv
// Self-checking bench for str_frame: cycle table for a plain frame, scripted
// corner sequences and a randomised run, all checked by a beat scoreboard.
module tb_str_frame;
   localparam int DW = 8;
   localparam int LW = 16;

   logic clk;
   logic rst;
   logic busy;

   str_frame_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   str_frame #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          cfg_val;
      logic [LW-1:0] cfg_len;
      logic          up_val;
      logic [DW-1:0] up_data;
      logic          dn_rdy;
      logic [3:0]    exp_flags;
      logic [DW-1:0] exp_data;
      logic          exp_last;
   } vec_t;

   vec_t          vecs[7];
   logic [DW:0]   sb_q[$];
   int            m_remain;
   int            errors;
   int            checks;
   int            popped;
   int            lasts;
   logic          cfg_took;
   logic          rand_mode;
   logic          toggle_mode;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.cfg_val = v.cfg_val;
      bus.cfg_len = v.cfg_len;
      bus.up_val  = v.up_val;
      bus.up_data = v.up_data;
      bus.dn_rdy  = v.dn_rdy;
   endtask

   // Scoreboard: expected beats queued on each upstream transfer with the
   // bench's own last tag, compared whenever the output is valid.
   always @(negedge clk) begin
      if (!rst) begin
         sb_q.delete();
         m_remain = 0;
      end else begin
         if (bus.dn_val) begin
            checkOutput("dn beat has expected entry", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               checkOutput("dn beat {last,data}", 32'({bus.dn_last, bus.dn_data}),
                           32'(sb_q[0]));
               if (bus.dn_rdy) begin
                  void'(sb_q.pop_front());
                  popped++;
                  if (bus.dn_last) lasts++;
               end
            end
         end
         if (bus.up_val && bus.up_rdy) begin
            checkOutput("up accepted inside frame", 32'(m_remain != 0), 1);
            if (m_remain != 0) begin
               sb_q.push_back({(m_remain == 1), bus.up_data});
               m_remain--;
            end
         end
         if (bus.cfg_val && bus.cfg_rdy) begin
            checkOutput("cfg accepted only when idle", 32'(m_remain == 0), 1);
            m_remain = int'(bus.cfg_len);
         end
      end
   end

   task automatic tick();
      logic took;
      @(negedge clk);
      took     = bus.up_val & bus.up_rdy & rst;
      cfg_took = bus.cfg_val & bus.cfg_rdy & rst;
      @(posedge clk);
      #1;
      if (took) bus.up_data = DW'($urandom);
      if (toggle_mode) bus.dn_rdy = ~bus.dn_rdy;
      if (rand_mode) begin
         bus.up_val = 1'($urandom_range(0, 1));
         bus.dn_rdy = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic sendCfg(input int len);
      int n;
      n = 0;
      bus.cfg_len = LW'(len);
      bus.cfg_val = 1'b1;
      do begin
         tick();
         n++;
      end while (!cfg_took && n < 200);
      bus.cfg_val = 1'b0;
      checkOutput("cfg accepted", 32'(cfg_took), 1);
   endtask

   task automatic waitFrame();
      int n;
      n = 0;
      while (m_remain != 0 && n < 2000) begin
         tick();
         n++;
      end
      checkOutput("frame completes", 32'(m_remain == 0), 1);
   endtask

   task automatic drainAll();
      int n;
      n = 0;
      rand_mode   = 1'b0;
      toggle_mode = 1'b0;
      bus.up_val  = 1'b0;
      bus.dn_rdy  = 1'b1;
      while ((sb_q.size() != 0 || busy) && n < 100) begin
         tick();
         n++;
      end
      checkOutput("busy after drain", 32'(busy), 0);
      checkOutput("scoreboard empty after drain", 32'(sb_q.size()), 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int p0;
      int l0;
      int total;
      errors = 0; checks = 0; popped = 0; lasts = 0; m_remain = 0;
      cfg_took = 1'b0; rand_mode = 1'b0; toggle_mode = 1'b0;
      rst = 1'b0;
      bus.cfg_val = 1'b0; bus.cfg_len = '0; bus.up_val = 1'b0;
      bus.up_data = '0; bus.dn_rdy = 1'b1;

      //              cfg  len  up  data   rdy  {cfg,up,dnv,busy} data   last
      vecs[0] = '{1'b1, 16'd4, 1'b1, 8'hA0, 1'b1, 4'b1000, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 16'd0, 1'b1, 8'hA0, 1'b1, 4'b0101, 8'h00, 1'b0};
      vecs[2] = '{1'b0, 16'd0, 1'b1, 8'hA1, 1'b1, 4'b0111, 8'hA0, 1'b0};
      vecs[3] = '{1'b0, 16'd0, 1'b1, 8'hA2, 1'b1, 4'b0111, 8'hA1, 1'b0};
      vecs[4] = '{1'b0, 16'd0, 1'b1, 8'hA3, 1'b1, 4'b0111, 8'hA2, 1'b0};
      vecs[5] = '{1'b0, 16'd0, 1'b1, 8'hA4, 1'b1, 4'b1011, 8'hA3, 1'b1};
      vecs[6] = '{1'b0, 16'd0, 1'b0, 8'hA4, 1'b1, 4'b1000, 8'h00, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset cfg_rdy", 32'(bus.cfg_rdy), 0);
      checkOutput("reset up_rdy", 32'(bus.up_rdy), 0);
      checkOutput("reset dn_val", 32'(bus.dn_val), 0);
      checkOutput("reset dn_last", 32'(bus.dn_last), 0);
      checkOutput("reset dn_data", 32'(bus.dn_data), 0);
      checkOutput("reset busy", 32'(busy), 0);
      rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d {cfg_rdy,up_rdy,dn_val,busy}", i),
                     32'({bus.cfg_rdy, bus.up_rdy, bus.dn_val, busy}),
                     32'(vecs[i].exp_flags));
         if (vecs[i].exp_flags[1]) begin
            checkOutput($sformatf("vec%0d {dn_last,dn_data}", i),
                        32'({bus.dn_last, bus.dn_data}),
                        32'({vecs[i].exp_last, vecs[i].exp_data}));
         end
         @(posedge clk);
         #1;
      end

      $display("[TB] stall with skid, len 3");
      p0 = popped; l0 = lasts;
      bus.up_val = 1'b1; bus.dn_rdy = 1'b1;
      sendCfg(3);
      tick();
      bus.dn_rdy = 1'b0;
      tick();
      checkOutput("stall up_rdy low (1)", 32'(bus.up_rdy), 0);
      tick();
      checkOutput("stall up_rdy low (2)", 32'(bus.up_rdy), 0);
      tick();
      bus.dn_rdy = 1'b1;
      waitFrame();
      drainAll();
      checkOutput("stall beats", 32'(popped - p0), 3);
      checkOutput("stall lasts", 32'(lasts - l0), 1);

      $display("[TB] zero length then length 1");
      p0 = popped; l0 = lasts;
      bus.up_val = 1'b1;
      sendCfg(0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("len0 cfg_rdy", 32'(bus.cfg_rdy), 1);
         checkOutput("len0 up_rdy", 32'(bus.up_rdy), 0);
         checkOutput("len0 dn_val", 32'(bus.dn_val), 0);
         tick();
      end
      sendCfg(1);
      waitFrame();
      drainAll();
      checkOutput("len1 beats", 32'(popped - p0), 1);
      checkOutput("len1 lasts", 32'(lasts - l0), 1);

      $display("[TB] back-to-back len 2 frames, dn_rdy toggling");
      p0 = popped; l0 = lasts;
      bus.up_val = 1'b1; bus.dn_rdy = 1'b1; toggle_mode = 1'b1;
      sendCfg(2);
      waitFrame();
      sendCfg(2);
      waitFrame();
      drainAll();
      checkOutput("b2b beats", 32'(popped - p0), 4);
      checkOutput("b2b lasts", 32'(lasts - l0), 2);

      $display("[TB] reset mid-frame");
      bus.up_val = 1'b1; bus.dn_rdy = 1'b0;
      sendCfg(8);
      repeat (4) tick();
      rst = 1'b0;
      tick();
      checkOutput("midreset cfg_rdy", 32'(bus.cfg_rdy), 0);
      checkOutput("midreset dn_val", 32'(bus.dn_val), 0);
      checkOutput("midreset busy", 32'(busy), 0);
      rst = 1'b1;
      bus.dn_rdy = 1'b1;
      #1;
      checkOutput("post-reset cfg_rdy", 32'(bus.cfg_rdy), 1);
      checkOutput("post-reset dn_val", 32'(bus.dn_val), 0);
      p0 = popped; l0 = lasts;
      sendCfg(2);
      waitFrame();
      drainAll();
      checkOutput("post-reset beats", 32'(popped - p0), 2);
      checkOutput("post-reset lasts", 32'(lasts - l0), 1);

      $display("[TB] random traffic");
      p0 = popped; l0 = lasts; total = 0;
      rand_mode = 1'b1;
      for (int f = 0; f < 25; f++) begin
         int len;
         len = $urandom_range(1, 16);
         total += len;
         sendCfg(len);
         waitFrame();
      end
      drainAll();
      checkOutput("random beats", 32'(popped - p0), 32'(total));
      checkOutput("random lasts", 32'(lasts - l0), 25);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
